// File: rtl/arith_datapath_if.sv
// Operand/result bundle for arith_datapath.
// The issuing stage drives A/B/opcode and the datapath returns Y/co.
interface arith_datapath_if #(
    parameter int N = 16
);
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   opcode;
    logic [N-1:0] Y;
    logic         co;

    modport master (
        output A, B, opcode,
        input  Y, co
    );

    modport slave (
        input  A, B, opcode,
        output Y, co
    );
endinterface

// File: rtl/arith_datapath.sv
// Signed N-bit ALU datapath with PIPE (0..2) extra stages.
// Accepts one op per cycle; result and flag are registered.
module arith_datapath #(
    parameter int N    = 16,
    parameter int PIPE = 1
) (
    input  logic            clk,
    input  logic            rst,
    arith_datapath_if.slave bus
);
    localparam int SH = $clog2(N);

    logic [N-1:0] a_s;
    logic [N-1:0] b_s;
    logic [2:0]   op_s;

    generate
        if (PIPE >= 1) begin : g_in_reg
            logic [N-1:0] a_q;
            logic [N-1:0] b_q;
            logic [2:0]   op_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    op_q <= '0;
                end else begin
                    a_q  <= bus.A;
                    b_q  <= bus.B;
                    op_q <= bus.opcode;
                end
            end

            assign a_s  = a_q;
            assign b_s  = b_q;
            assign op_s = op_q;
        end else begin : g_in_comb
            assign a_s  = bus.A;
            assign b_s  = bus.B;
            assign op_s = bus.opcode;
        end
    endgenerate

    logic [N:0]     add_d;
    logic [N:0]     sub_d;
    logic [2*N-1:0] a_ext;
    logic [2*N-1:0] b_ext;
    logic [2*N-1:0] mul_d;
    logic [N-1:0]   and_d;
    logic [N-1:0]   or_d;
    logic [N-1:0]   xor_d;
    logic [N-1:0]   relu_d;
    logic [N-1:0]   asr_d;

    // Sign-extend to 2N so the low 2N bits of the unsigned product are the signed product.
    assign a_ext  = {{N{a_s[N-1]}}, a_s};
    assign b_ext  = {{N{b_s[N-1]}}, b_s};
    assign add_d  = {1'b0, a_s} + {1'b0, b_s};
    assign sub_d  = {1'b0, a_s} + {1'b0, ~b_s} + {{N{1'b0}}, 1'b1};
    assign mul_d  = a_ext * b_ext;
    assign and_d  = a_s & b_s;
    assign or_d   = a_s | b_s;
    assign xor_d  = a_s ^ b_s;
    assign relu_d = a_s[N-1] ? '0 : a_s;
    assign asr_d  = $signed(a_s) >>> b_s[SH-1:0];

    logic [N:0]     add_m;
    logic [N:0]     sub_m;
    logic [2*N-1:0] mul_m;
    logic [N-1:0]   and_m;
    logic [N-1:0]   or_m;
    logic [N-1:0]   xor_m;
    logic [N-1:0]   relu_m;
    logic [N-1:0]   asr_m;
    logic [2:0]     op_m;

    generate
        if (PIPE == 2) begin : g_mid_reg
            logic [N:0]     add_q;
            logic [N:0]     sub_q;
            logic [2*N-1:0] mul_q;
            logic [N-1:0]   and_q;
            logic [N-1:0]   or_q;
            logic [N-1:0]   xor_q;
            logic [N-1:0]   relu_q;
            logic [N-1:0]   asr_q;
            logic [2:0]     op_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    add_q  <= '0;
                    sub_q  <= '0;
                    mul_q  <= '0;
                    and_q  <= '0;
                    or_q   <= '0;
                    xor_q  <= '0;
                    relu_q <= '0;
                    asr_q  <= '0;
                    op_q   <= '0;
                end else begin
                    add_q  <= add_d;
                    sub_q  <= sub_d;
                    mul_q  <= mul_d;
                    and_q  <= and_d;
                    or_q   <= or_d;
                    xor_q  <= xor_d;
                    relu_q <= relu_d;
                    asr_q  <= asr_d;
                    op_q   <= op_s;
                end
            end

            assign add_m  = add_q;
            assign sub_m  = sub_q;
            assign mul_m  = mul_q;
            assign and_m  = and_q;
            assign or_m   = or_q;
            assign xor_m  = xor_q;
            assign relu_m = relu_q;
            assign asr_m  = asr_q;
            assign op_m   = op_q;
        end else begin : g_mid_comb
            assign add_m  = add_d;
            assign sub_m  = sub_d;
            assign mul_m  = mul_d;
            assign and_m  = and_d;
            assign or_m   = or_d;
            assign xor_m  = xor_d;
            assign relu_m = relu_d;
            assign asr_m  = asr_d;
            assign op_m   = op_s;
        end
    endgenerate

    // Product fits in N bits only when the top N+1 bits are a pure sign extension.
    logic mul_ovf;
    assign mul_ovf = !((&mul_m[2*N-1:N-1]) || !(|mul_m[2*N-1:N-1]));

    logic [N-1:0] y_d;
    logic         co_d;
    logic [N-1:0] y_q;
    logic         co_q;

    always_comb begin
        y_d  = '0;
        co_d = 1'b0;
        unique case (op_m)
            3'b000: begin
                y_d  = add_m[N-1:0];
                co_d = add_m[N];
            end
            3'b001: begin
                y_d  = sub_m[N-1:0];
                co_d = sub_m[N];
            end
            3'b010: begin
                y_d  = mul_m[N-1:0];
                co_d = mul_ovf;
            end
            3'b011: y_d = and_m;
            3'b100: y_d = or_m;
            3'b101: y_d = xor_m;
            3'b110: y_d = relu_m;
            3'b111: y_d = asr_m;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q  <= '0;
            co_q <= 1'b0;
        end else begin
            y_q  <= y_d;
            co_q <= co_d;
        end
    end

    assign bus.Y  = y_q;
    assign bus.co = co_q;
endmodule

// File: tb/tb_arith_datapath.sv
// Bench for arith_datapath: PIPE=0/1/2 instances share one stimulus stream
// and are checked against per-edge expected results with per-instance latency.
module tb_arith_datapath;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;

    always #5 clk = ~clk;

    arith_datapath_if #(.N(N)) bus0 ();
    arith_datapath_if #(.N(N)) bus1 ();
    arith_datapath_if #(.N(N)) bus2 ();

    assign bus0.A = a;
    assign bus0.B = b;
    assign bus0.opcode = op;
    assign bus1.A = a;
    assign bus1.B = b;
    assign bus1.opcode = op;
    assign bus2.A = a;
    assign bus2.B = b;
    assign bus2.opcode = op;

    arith_datapath #(.N(N), .PIPE(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );
    arith_datapath #(.N(N), .PIPE(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );
    arith_datapath #(.N(N), .PIPE(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    logic [N-1:0] y_o [3];
    logic         co_o [3];
    assign y_o[0]  = bus0.Y;
    assign y_o[1]  = bus1.Y;
    assign y_o[2]  = bus2.Y;
    assign co_o[0] = bus0.co;
    assign co_o[1] = bus1.co;
    assign co_o[2] = bus2.co;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [N-1:0] ey [$];
    logic         ec [$];
    bit           er [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [2:0] o,
                                          input logic [15:0] x,
                                          input logic [15:0] y);
        int unsigned s;
        longint      pr;
        logic [15:0] t;
        logic [15:0] r;
        logic        c;
        r = '0;
        c = 1'b0;
        case (o)
            3'd0: begin
                s = 32'(x) + 32'(y);
                r = s[15:0];
                c = s[16];
            end
            3'd1: begin
                r = x - y;
                c = (x >= y);
            end
            3'd2: begin
                pr = longint'($signed(x)) * longint'($signed(y));
                r  = pr[15:0];
                c  = (pr > 32767) || (pr < -32768);
            end
            3'd3: r = x & y;
            3'd4: r = x | y;
            3'd5: r = x ^ y;
            3'd6: r = x[15] ? 16'h0000 : x;
            default: begin
                t = x;
                for (int i = 0; i < int'(y[3:0]); i++) t = {t[15], t[15:1]};
                r = t;
            end
        endcase
        return {c, r};
    endfunction

    // Output after edge e of the PIPE=p instance is entry e-p,
    // or zero if rst was high on any edge in [e-p, e].
    task automatic step(input bit r, input logic [2:0] o,
                        input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic [N:0] res, input string tag);
        int e;
        bit z;
        logic [N-1:0] wy;
        logic wc;
        rst = r;
        op  = o;
        a   = x;
        b   = y;
        @(posedge clk);
        #1;
        er.push_back(r);
        ey.push_back(r ? '0 : res[N-1:0]);
        ec.push_back(r ? 1'b0 : res[N]);
        e = er.size() - 1;
        for (int p = 0; p < 3; p++) begin
            z = 1'b0;
            for (int j = e - p; j <= e; j++)
                if (j < 0 || er[j]) z = 1'b1;
            wy = '0;
            wc = 1'b0;
            if (!z) begin
                wy = ey[e-p];
                wc = ec[e-p];
            end
            chk($sformatf("%s.y.p%0d", tag, p), 32'(y_o[p]), 32'(wy));
            chk($sformatf("%s.co.p%0d", tag, p), 32'(co_o[p]), 32'(wc));
        end
    endtask

    task automatic rnd(input bit r, input string tag);
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [2:0]   o;
        x = N'($urandom);
        y = N'($urandom);
        o = 3'($urandom_range(7));
        step(r, o, x, y, model(o, x, y), tag);
    endtask

    initial begin
        rst = 1'b1;
        a   = '0;
        b   = '0;
        op  = '0;

        rnd(1'b1, "rst0");
        rnd(1'b1, "rst1");

        step(0, 3'b000, 16'h7FFF, 16'h0001, {1'b0, 16'h8000}, "add_pos_wrap");
        step(0, 3'b000, 16'hFFFF, 16'h0001, {1'b1, 16'h0000}, "add_carry");
        step(0, 3'b001, 16'h0005, 16'h0007, {1'b0, 16'hFFFE}, "sub_neg");
        step(0, 3'b001, 16'h0007, 16'h0005, {1'b1, 16'h0002}, "sub_pos");
        step(0, 3'b001, 16'h8000, 16'h0001, {1'b1, 16'h7FFF}, "sub_min_wrap");
        step(0, 3'b001, 16'h0005, 16'h0005, {1'b1, 16'h0000}, "sub_eq");
        step(0, 3'b010, 16'h0064, 16'hFFFD, {1'b0, 16'hFED4}, "mul_neg");
        step(0, 3'b010, 16'h012C, 16'h012C, {1'b1, 16'h5F90}, "mul_ovf");
        step(0, 3'b010, 16'h8000, 16'hFFFF, {1'b1, 16'h8000}, "mul_min");
        step(0, 3'b011, 16'hF0F0, 16'h0FF0, {1'b0, 16'h00F0}, "and");
        step(0, 3'b100, 16'hF0F0, 16'h0FF0, {1'b0, 16'hFFF0}, "or");
        step(0, 3'b101, 16'hF0F0, 16'h0FF0, {1'b0, 16'hFF00}, "xor");
        step(0, 3'b110, 16'hFFFB, 16'h1234, {1'b0, 16'h0000}, "relu_neg");
        step(0, 3'b110, 16'h002A, 16'hFFFF, {1'b0, 16'h002A}, "relu_pos");
        step(0, 3'b111, 16'hFFC0, 16'h0003, {1'b0, 16'hFFF8}, "asr_neg");
        step(0, 3'b111, 16'h4000, 16'h000F, {1'b0, 16'h0000}, "asr_max_pos");
        step(0, 3'b111, 16'h8000, 16'h000F, {1'b0, 16'hFFFF}, "asr_max_neg");
        step(0, 3'b111, 16'h8123, 16'h0010, {1'b0, 16'h8123}, "asr_zero");

        repeat (20) rnd(1'b0, "stream");
        rnd(1'b1, "midrst");
        repeat (20) rnd(1'b0, "post");
        step(0, 3'b000, 16'h0000, 16'h0000, {1'b0, 16'h0000}, "drain0");
        step(0, 3'b000, 16'h0000, 16'h0000, {1'b0, 16'h0000}, "drain1");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
